// File: rtl/uart_pkg.sv
// uart_pkg: shared UART TX constants, output-mux select codes and sequencer state encoding.
// Contents:
//    DEF_DATA_WIDTH / DEF_TICKS_PER_BIT - default frame geometry
//    SEL_START / SEL_STOP / SEL_DATA / SEL_PARITY - TX output mux select codes
//    tx_state_t - transmit sequencer states
package uart_pkg;
   localparam int DEF_DATA_WIDTH    = 8;
   localparam int DEF_TICKS_PER_BIT = 16;
   localparam logic [1:0] SEL_START  = 2'b00;
   localparam logic [1:0] SEL_STOP   = 2'b01;
   localparam logic [1:0] SEL_DATA   = 2'b10;
   localparam logic [1:0] SEL_PARITY = 2'b11;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} tx_state_t;
endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts oversampled baud ticks and flags the final tick of each bit period.
// Ports:
//    clk, rst  - clock, asynchronous active-high reset
//    clear     - hold the counter at zero (wins over tick)
//    tick      - one-clk baud tick pulse
//    bit_end   - high on the tick that completes a bit period
module uart_tx_bit_timer #(
   parameter int TICKS_PER_BIT = 16,
   localparam int CW = $clog2(TICKS_PER_BIT)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic bit_end
);
   logic [CW-1:0] cnt;
   assign bit_end = tick && !clear && (cnt == CW'(TICKS_PER_BIT - 1));
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (tick)
         cnt <= bit_end ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer driving the TX output mux selects, one bit per TICKS_PER_BIT baud ticks.
// Ports:
//    clk, rst                 - clock, asynchronous active-high reset
//    baud_tick                - oversampled baud tick pulse
//    tx_data/tx_valid/tx_ready - byte handshake, accepted only in IDLE
//    parity_en/parity_odd/two_stop - frame format, latched at acceptance
//    bit_select               - output mux select (start/stop/data/parity)
//    serial_data              - current data bit (LSB of the shift register)
//    parity_bit               - parity of the latched byte
//    tx_busy / tx_done        - frame in progress / one-clk completion pulse
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH    = uart_pkg::DEF_DATA_WIDTH,
   parameter int TICKS_PER_BIT = uart_pkg::DEF_TICKS_PER_BIT,
   parameter logic [1:0] SEL_START  = uart_pkg::SEL_START,
   parameter logic [1:0] SEL_STOP   = uart_pkg::SEL_STOP,
   parameter logic [1:0] SEL_DATA   = uart_pkg::SEL_DATA,
   parameter logic [1:0] SEL_PARITY = uart_pkg::SEL_PARITY
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  baud_tick,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic                  parity_en,
   input  logic                  parity_odd,
   input  logic                  two_stop,
   output logic [1:0]            bit_select,
   output logic                  serial_data,
   output logic                  parity_bit,
   output logic                  tx_busy,
   output logic                  tx_done
);
   localparam int BW = $clog2(DATA_WIDTH);
   tx_state_t state, state_n;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [BW-1:0] bit_cnt;
   logic par_en_q, two_stop_q;
   logic bit_end, accept, last_bit;
   logic [1:0] sel_n;
   assign accept      = tx_valid && tx_ready;
   assign last_bit    = bit_cnt == BW'(DATA_WIDTH - 1);
   assign serial_data = shift_reg[0];
   // Held clear throughout IDLE, so a tick coinciding with acceptance is not counted.
   uart_tx_bit_timer #(.TICKS_PER_BIT(TICKS_PER_BIT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == IDLE),
      .tick    (baud_tick),
      .bit_end (bit_end)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = accept ? START : IDLE;
         START:   state_n = bit_end ? DATA : START;
         DATA:    state_n = (bit_end && last_bit) ? (par_en_q ? PARITY : STOP1) : DATA;
         PARITY:  state_n = bit_end ? STOP1 : PARITY;
         STOP1:   state_n = bit_end ? (two_stop_q ? STOP2 : IDLE) : STOP1;
         STOP2:   state_n = bit_end ? IDLE : STOP2;
         default: state_n = IDLE;
      endcase
      sel_n = state_n == START  ? SEL_START  :
              state_n == DATA   ? SEL_DATA   :
              state_n == PARITY ? SEL_PARITY : SEL_STOP;
   end
   // Outputs are registered from the next state so they change on the same edge as the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_select <= SEL_STOP;
         tx_busy    <= 1'b0;
         tx_ready   <= 1'b1;
         tx_done    <= 1'b0;
         shift_reg  <= '0;
         parity_bit <= 1'b0;
         bit_cnt    <= '0;
         par_en_q   <= 1'b0;
         two_stop_q <= 1'b0;
      end else begin
         bit_select <= sel_n;
         tx_busy    <= state_n != IDLE;
         tx_ready   <= state_n == IDLE;
         tx_done    <= state != IDLE && state_n == IDLE;
         if (accept) begin
            shift_reg  <= tx_data;
            parity_bit <= ^tx_data ^ parity_odd;
            bit_cnt    <= '0;
            par_en_q   <= parity_en;
            two_stop_q <= two_stop;
         end else if (state == DATA && bit_end) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed self-checking bench for uart_tx_ctrl decoding the muxed serial line bit by bit.
module tb_uart_tx_ctrl;
   logic clk = 0, rst = 1, baud_tick = 0, tx_valid = 0;
   logic parity_en = 0, parity_odd = 0, two_stop = 0;
   logic [7:0] tx_data = '0;
   logic tx_ready, serial_data, parity_bit, tx_busy, tx_done;
   logic [1:0] bit_select;
   int vectors = 0, miscompares = 0;
   logic [1:0] exp_sel[12];
   logic exp_line[12];

   uart_tx_ctrl dut (
      .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
      .bit_select(bit_select), .serial_data(serial_data), .parity_bit(parity_bit),
      .tx_busy(tx_busy), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   function automatic logic line_of(input logic [1:0] s, input logic d, input logic p);
      return s == 2'b00 ? 1'b0 : s == 2'b01 ? 1'b1 : s == 2'b10 ? d : p;
   endfunction

   task automatic do_tick();
      baud_tick = 1;
      @(negedge clk);
      baud_tick = 0;
   endtask

   task automatic build_exp(input logic [7:0] d, input bit pe, input logic par, input bit ts, output int n);
      int k;
      exp_sel[0] = 2'b00; exp_line[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_sel[1+i] = 2'b10; exp_line[1+i] = d[i];
      end
      k = 9;
      if (pe) begin exp_sel[k] = 2'b11; exp_line[k] = par; k++; end
      exp_sel[k] = 2'b01; exp_line[k] = 1'b1; k++;
      if (ts) begin exp_sel[k] = 2'b01; exp_line[k] = 1'b1; k++; end
      n = k;
   endtask

   task automatic start_frame(input logic [7:0] d, input bit pe, input bit po, input bit ts,
                              input bit keep, input bit tick);
      tx_data = d; parity_en = pe; parity_odd = po; two_stop = ts;
      tx_valid = 1; baud_tick = tick;
      @(negedge clk);
      tx_valid = keep; baud_tick = 0;
   endtask

   task automatic run_frame(input string name, input int n, input bit flip);
      for (int b = 0; b < n; b++) begin
         if (flip && b == 2) begin
            parity_odd = ~parity_odd; parity_en = ~parity_en; two_stop = ~two_stop;
         end
         vectors++;
         if (bit_select !== exp_sel[b]) begin
            miscompares++;
            $display("FAIL %s sel bit%0d: got %b expected %b", name, b, bit_select, exp_sel[b]);
         end
         vectors++;
         if (line_of(bit_select, serial_data, parity_bit) !== exp_line[b]) begin
            miscompares++;
            $display("FAIL %s line bit%0d: got %b expected %b", name, b,
                     line_of(bit_select, serial_data, parity_bit), exp_line[b]);
         end
         vectors++;
         if (tx_busy !== 1'b1 || tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy/ready bit%0d: got %b/%b expected 1/0", name, b, tx_busy, tx_ready);
         end
         for (int t = 0; t < 16; t++) begin
            do_tick();
            if (t == 14) begin
               vectors++;
               if (bit_select !== exp_sel[b]) begin
                  miscompares++;
                  $display("FAIL %s hold bit%0d: got %b expected %b", name, b, bit_select, exp_sel[b]);
               end
            end
            if (t != 15) @(negedge clk);
         end
      end
      vectors++;
      if (tx_done !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || bit_select !== 2'b01) begin
         miscompares++;
         $display("FAIL %s end done/ready/busy/sel: got %b/%b/%b/%b expected 1/1/0/01",
                  name, tx_done, tx_ready, tx_busy, bit_select);
      end
      @(negedge clk);
      vectors++;
      if (tx_done !== 1'b0) begin
         miscompares++;
         $display("FAIL %s done pulse width: got %b expected 0", name, tx_done);
      end
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) @(negedge clk);
      vectors++;
      if (bit_select !== 2'b01 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0 ||
          serial_data !== 1'b0 || parity_bit !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: sel/ready/busy/done/sd/par got %b/%b/%b/%b/%b/%b expected 01/1/0/0/0/0",
                  bit_select, tx_ready, tx_busy, tx_done, serial_data, parity_bit);
      end
      rst = 0;
      @(negedge clk);
   endtask

   task automatic test_8n1();
      int n;
      build_exp(8'hA5, 0, 1'b0, 0, n);
      start_frame(8'hA5, 0, 0, 0, 0, 0);
      run_frame("8n1_a5", n, 0);
   endtask

   task automatic test_8e2();
      int n;
      build_exp(8'h07, 1, 1'b1, 1, n);
      start_frame(8'h07, 1, 0, 1, 0, 0);
      vectors++;
      if (parity_bit !== 1'b1) begin
         miscompares++;
         $display("FAIL 8e2 parity_bit: got %b expected 1", parity_bit);
      end
      run_frame("8e2_07", n, 0);
   endtask

   task automatic test_8o1_flip();
      int n;
      build_exp(8'h00, 1, 1'b1, 0, n);
      start_frame(8'h00, 1, 1, 0, 0, 0);
      vectors++;
      if (parity_bit !== 1'b1) begin
         miscompares++;
         $display("FAIL 8o1 parity_bit: got %b expected 1", parity_bit);
      end
      run_frame("8o1_flip", n, 1);
      parity_en = 0; parity_odd = 0; two_stop = 0;
   endtask

   task automatic test_back_to_back();
      int n;
      build_exp(8'h55, 0, 1'b0, 0, n);
      start_frame(8'h55, 0, 0, 0, 1, 0);
      tx_data = 8'hAA;
      run_frame("b2b_55", n, 0);
      vectors++;
      if (bit_select !== 2'b00 || tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b restart sel/ready/busy: got %b/%b/%b expected 00/0/1",
                  bit_select, tx_ready, tx_busy);
      end
      tx_valid = 0;
      build_exp(8'hAA, 0, 1'b0, 0, n);
      run_frame("b2b_aa", n, 0);
   endtask

   task automatic test_reset_mid();
      int n;
      start_frame(8'h5A, 0, 0, 0, 0, 0);
      for (int i = 0; i < 69; i++) begin
         do_tick();
         @(negedge clk);
      end
      vectors++;
      if (bit_select !== 2'b10 || serial_data !== 1'b1) begin
         miscompares++;
         $display("FAIL midframe sel/data bit3: got %b/%b expected 10/1", bit_select, serial_data);
      end
      rst = 1;
      #1;
      vectors++;
      if (bit_select !== 2'b01 || tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL async reset sel/busy/ready: got %b/%b/%b expected 01/0/1",
                  bit_select, tx_busy, tx_ready);
      end
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      build_exp(8'h3C, 0, 1'b0, 0, n);
      start_frame(8'h3C, 0, 0, 0, 0, 0);
      run_frame("after_reset_3c", n, 0);
   endtask

   task automatic test_coincident_tick();
      int n;
      build_exp(8'hC3, 0, 1'b0, 0, n);
      start_frame(8'hC3, 0, 0, 0, 0, 1);
      run_frame("coincident_c3", n, 0);
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_8e2();
      test_8o1_flip();
      test_back_to_back();
      test_reset_mid();
      test_coincident_tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
